// File: rtl/addsub_seq_nb_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
//   state_e     : control FSM states (IDLE, RUN, DONE)
//   calc_ndig   : number of DIGIT-bit slices in a W-bit operand
//   calc_cnt_w  : digit counter width, clog2(NDIG) but never less than 1
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_ndig(input int w, input int digit);
    return w / digit;
  endfunction

  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/addsub_seq_nb_if.sv
// Operand/result handshake bundle for addsub_seq_nb.
//   in_valid/in_ready   : operand handshake (a, b, sub, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
// master = operand producer / result consumer, slave = the adder.
interface addsub_seq_nb_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/addsub_seq_nb_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full_adder cells.
//   full_adder  : a, b, ci -> s, co
//   digit_adder : a, b (DIGIT bits), cin -> s (DIGIT bits), cout,
//                 c_top = carry into the most significant bit of the slice
//                 (on the last slice this is the carry into bit W-1, used
//                 for signed overflow).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_top
);
  // carry[i] is the carry into bit i; carry[DIGIT] leaves the slice.
  logic [DIGIT:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_fa
      full_adder u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (carry[gi]),
        .s  (s[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  assign cout  = carry[DIGIT];
  assign c_top = carry[DIGIT-1];
endmodule

// File: rtl/addsub_seq_nb.sv
// Digit-serial W-bit adder/subtractor behind valid/ready handshakes.
// One DIGIT-bit slice is added per clock with the carry kept in a register;
// the result is valid NDIG cycles after the operands are accepted and held
// until the consumer takes it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : addsub_seq_nb_if slave (operands in, result out)
module addsub_seq_nb
  import addsub_seq_pkg::*;
#(
  parameter int W     = 16,
  parameter int DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  addsub_seq_nb_if.slave  bus
);

  localparam int NDIG = calc_ndig(W, DIGIT);
  localparam int CW   = calc_cnt_w(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if ((W < 1) || (DIGIT < 1) || ((W % DIGIT) != 0)) begin : g_bad_params
      $error("addsub_seq_nb: DIGIT must be >= 1 and divide W");
    end
  endgenerate

  state_e state_reg, state_next;

  logic [W-1:0]  a_reg, b_reg, res_reg, sum_reg;
  logic          carry_reg, cout_reg, ovf_reg;
  logic [CW-1:0] cnt_reg;

  logic             load, step, last_digit;
  logic             in_ready_c, out_valid_c;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout, d_ctop;
  logic [W-1:0]     res_shift;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_reg[DIGIT-1:0]),
    .b     (b_reg[DIGIT-1:0]),
    .cin   (carry_reg),
    .s     (d_sum),
    .cout  (d_cout),
    .c_top (d_ctop)
  );

  // New slice enters at the MSB end, so after NDIG steps slice 0 sits at
  // the bottom of the word.
  generate
    if (NDIG == 1) begin : g_single
      assign res_shift = d_sum;
    end else begin : g_multi
      assign res_shift = {d_sum, res_reg[W-1:DIGIT]};
    end
  endgenerate

  assign last_digit = (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    load        = 1'b0;
    step        = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (load) begin
      // Subtraction is a + ~b + ~cin, so invert once at capture time.
      a_reg     <= bus.a;
      b_reg     <= bus.sub ? ~bus.b : bus.b;
      carry_reg <= bus.sub ? ~bus.cin : bus.cin;
      cnt_reg   <= '0;
    end else if (step) begin
      a_reg     <= a_reg >> DIGIT;
      b_reg     <= b_reg >> DIGIT;
      res_reg   <= res_shift;
      carry_reg <= d_cout;
      cnt_reg   <= cnt_reg + 1'b1;
      if (last_digit) begin
        sum_reg  <= res_shift;
        cout_reg <= d_cout;
        ovf_reg  <= d_ctop ^ d_cout;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_addsub_seq_nb.sv
module tb_addsub_seq_nb;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  addsub_seq_nb_if #(.W(16)) bus16 ();
  addsub_seq_nb_if #(.W(8))  bus8 ();
  addsub_seq_nb_if #(.W(12)) bus12 ();

  addsub_seq_nb #(.W(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  addsub_seq_nb #(.W(8),  .DIGIT(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  addsub_seq_nb #(.W(12), .DIGIT(1)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All op tasks start #1 after a rising edge with the DUT idle.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                      output logic [15:0] rs, output logic rc, output logic ro, output int lat);
    bus16.a = a; bus16.b = b; bus16.sub = s; bus16.cin = c; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0; bus16.a = ~a; bus16.b = ~b; bus16.sub = ~s; bus16.cin = ~c;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    rs = bus16.sum; rc = bus16.cout; ro = bus16.ovf;
    bus16.out_ready = 1'b1; @(posedge clk); #1; bus16.out_ready = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                     output logic [7:0] rs, output logic rc, output logic ro, output int lat);
    bus8.a = a; bus8.b = b; bus8.sub = s; bus8.cin = c; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0; bus8.a = ~a; bus8.b = ~b;
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    rs = bus8.sum; rc = bus8.cout; ro = bus8.ovf;
    bus8.out_ready = 1'b1; @(posedge clk); #1; bus8.out_ready = 1'b0;
  endtask

  task automatic op12(input logic [11:0] a, input logic [11:0] b, input logic s, input logic c,
                      output logic [11:0] rs, output logic rc, output logic ro, output int lat);
    bus12.a = a; bus12.b = b; bus12.sub = s; bus12.cin = c; bus12.in_valid = 1'b1;
    @(posedge clk); #1;
    bus12.in_valid = 1'b0; bus12.a = ~a; bus12.b = ~b;
    lat = 0;
    while (bus12.out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    rs = bus12.sum; rc = bus12.cout; ro = bus12.ovf;
    bus12.out_ready = 1'b1; @(posedge clk); #1; bus12.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r16, held_sum;
    logic        rc, ro, held_c, held_o;
    int          lat;
    logic [7:0]  a8, b8, r8, be8;
    logic [8:0]  e8;
    logic [11:0] a12, b12, r12, be12;
    logic [12:0] e12;
    logic        s, c, ci;

    tests = 0; fails = 0;
    rst_n = 1'b0;
    bus16.in_valid = 0; bus16.out_ready = 0; bus16.a = 0; bus16.b = 0; bus16.sub = 0; bus16.cin = 0;
    bus8.in_valid  = 0; bus8.out_ready  = 0; bus8.a  = 0; bus8.b  = 0; bus8.sub  = 0; bus8.cin  = 0;
    bus12.in_valid = 0; bus12.out_ready = 0; bus12.a = 0; bus12.b = 0; bus12.sub = 0; bus12.cin = 0;

    #2;
    check("rst_in_ready", bus16.in_ready, 1);
    check("rst_out_valid", bus16.out_valid, 0);
    check("rst_sum", bus16.sum, 0);
    check("rst_cout", bus16.cout, 0);
    check("rst_ovf", bus16.ovf, 0);
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add plus latency
    op16(16'h1234, 16'h0FFF, 0, 0, r16, rc, ro, lat);
    $display("[TB] add 1234+0FFF -> sum=%h cout=%b ovf=%b lat=%0d", r16, rc, ro, lat);
    check("add_sum", r16, 16'h2233); check("add_cout", rc, 0); check("add_ovf", ro, 0); check("add_lat", lat, 4);

    op16(16'h7FFF, 16'h0001, 0, 0, r16, rc, ro, lat);
    $display("[TB] add 7FFF+0001 -> sum=%h cout=%b ovf=%b", r16, rc, ro);
    check("ovf_sum", r16, 16'h8000); check("ovf_cout", rc, 0); check("ovf_ovf", ro, 1);

    op16(16'hFFFF, 16'h0000, 0, 1, r16, rc, ro, lat);
    $display("[TB] add FFFF+0000+1 -> sum=%h cout=%b ovf=%b", r16, rc, ro);
    check("wrap_sum", r16, 16'h0000); check("wrap_cout", rc, 1); check("wrap_ovf", ro, 0);

    op16(16'h0005, 16'h0007, 1, 0, r16, rc, ro, lat);
    $display("[TB] sub 0005-0007 -> sum=%h cout=%b ovf=%b", r16, rc, ro);
    check("sub_sum", r16, 16'hFFFE); check("sub_cout", rc, 0); check("sub_ovf", ro, 0);

    op16(16'h8000, 16'h0001, 1, 0, r16, rc, ro, lat);
    $display("[TB] sub 8000-0001 -> sum=%h cout=%b ovf=%b", r16, rc, ro);
    check("subovf_sum", r16, 16'h7FFF); check("subovf_cout", rc, 1); check("subovf_ovf", ro, 1);

    // Backpressure: 0x0100 + 0x00FF = 0x01FF
    bus16.a = 16'h0100; bus16.b = 16'h00FF; bus16.sub = 0; bus16.cin = 0; bus16.in_valid = 1;
    @(posedge clk); #1; bus16.in_valid = 0;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp_lat", lat, 4);
    held_sum = bus16.sum; held_c = bus16.cout; held_o = bus16.ovf;
    check("bp_sum", held_sum, 16'h01FF);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.in_valid = 1; end
      @(posedge clk); #1;
      bus16.in_valid = 0;
      check("bp_valid", bus16.out_valid, 1);
      check("bp_hold_sum", bus16.sum, held_sum);
      check("bp_hold_cout", bus16.cout, held_c);
      check("bp_hold_ovf", bus16.ovf, held_o);
      check("bp_in_ready", bus16.in_ready, 0);
    end
    bus16.out_ready = 1; @(posedge clk); #1; bus16.out_ready = 0;
    $display("[TB] backpressure op released sum=%h", held_sum);
    check("bp_rel_valid", bus16.out_valid, 0);
    check("bp_rel_ready", bus16.in_ready, 1);
    @(posedge clk); #1;
    check("bp_idle_ready", bus16.in_ready, 1);

    // Reset mid-op after 2 RUN cycles; previous result 0x01FF is still held.
    bus16.a = 16'h7FFF; bus16.b = 16'h7FFF; bus16.sub = 0; bus16.cin = 1; bus16.in_valid = 1;
    @(posedge clk); #1; bus16.in_valid = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b0; #1;
    $display("[TB] reset mid-op -> sum=%h out_valid=%b", bus16.sum, bus16.out_valid);
    check("midrst_sum", bus16.sum, 0);
    check("midrst_valid", bus16.out_valid, 0);
    check("midrst_cout", bus16.cout, 0);
    check("midrst_ovf", bus16.ovf, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", bus16.in_ready, 1);
    check("midrst_no_valid", bus16.out_valid, 0);
    op16(16'h0001, 16'h0001, 0, 0, r16, rc, ro, lat);
    $display("[TB] post-reset 0001+0001 -> sum=%h lat=%0d", r16, lat);
    check("post_sum", r16, 16'h0002); check("post_lat", lat, 4);

    // W=8, DIGIT=8 random sweep
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s = 1'($urandom); c = 1'($urandom);
      be8 = s ? ~b8 : b8; ci = s ? ~c : c;
      e8 = {1'b0, a8} + {1'b0, be8} + {8'd0, ci};
      op8(a8, b8, s, c, r8, rc, ro, lat);
      if (i < 4) $display("[TB] w8 a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b", a8, b8, s, c, r8, rc, ro);
      check("sw8_sum", r8, e8[7:0]);
      check("sw8_cout", rc, e8[8]);
      check("sw8_ovf", ro, (a8[7] == be8[7]) && (e8[7] != a8[7]));
      check("sw8_lat", lat, 1);
    end

    // W=12, DIGIT=1 random sweep
    for (int i = 0; i < 1000; i++) begin
      a12 = 12'($urandom); b12 = 12'($urandom); s = 1'($urandom); c = 1'($urandom);
      be12 = s ? ~b12 : b12; ci = s ? ~c : c;
      e12 = {1'b0, a12} + {1'b0, be12} + {12'd0, ci};
      op12(a12, b12, s, c, r12, rc, ro, lat);
      if (i < 4) $display("[TB] w12 a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b", a12, b12, s, c, r12, rc, ro);
      check("sw12_sum", r12, e12[11:0]);
      check("sw12_cout", rc, e12[12]);
      check("sw12_ovf", ro, (a12[11] == be12[11]) && (e12[11] != a12[11]));
      check("sw12_lat", lat, 12);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addsub_seq_nb.md
Name: addsub_seq_nb

Overview:
- Parametrised, digit-serial adder/subtractor. It is the multi-cycle successor to the fixed 4-bit ripple adder.
- Each clock it processes one DIGIT-bit slice of a W-bit operand pair.
- The carry is held in a register between slices.
- Sits behind a valid/ready handshake on both input and output, so datapaths can trade latency for area on wide operands.

Parameters:
- W, 16, operand/result width in bits. Must be >= 1.
- DIGIT, 4, bits processed per clock. Must be >= 1 and must divide W (elaboration-time check).

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  W  operand A
- b  in  W  operand B
- sub  in  1  0 = add, 1 = subtract
- cin  in  1  carry-in (add) / borrow-in (sub)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- cout  out  1  carry out of MSB (add); in sub mode, 1 = no borrow
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- NDIG = W/DIGIT.
- Reset values:
  - state IDLE
  - in_ready = 1
  - out_valid, sum, cout, ovf = 0
  - internal operand, result and carry registers = 0
  - digit counter = 0
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture a, b, sub.
  - Capture b_eff = sub ? ~b : b.
  - Carry register loads sub ? ~cin : cin.
  - Counter = 0; go to RUN.
- RUN (in_ready = 0):
  - Each cycle, add the low DIGIT bits of A and b_eff plus the carry register.
  - Shift the DIGIT-bit result into the MSB end of the result register; shift the operands right by DIGIT.
  - Update the carry register; increment the counter.
  - On the cycle the counter is NDIG-1:
    - cout = final carry.
    - ovf = (carry into bit W-1) XOR (carry out of bit W-1).
    - sum = full result; go to DONE.
- DONE:
  - out_valid = 1; sum, cout and ovf are held stable.
  - On out_ready: out_valid deasserts next cycle and the FSM returns to IDLE.
  - in_ready stays 0 in DONE, so there is no overlap. Max throughput is one op per NDIG+2 cycles.
- Latency: out_valid rises exactly NDIG cycles after the accepting edge.
- Arithmetic:
  - add: {cout,sum} = a + b + cin.
  - sub: {cout,sum} = a + ~b + ~cin, i.e. a - b - cin modulo 2^W. cout = 0 signals a borrow.
- Result and ovf are undefined (but stable) while out_valid = 0. Benches must only sample on out_valid.
- in_valid is ignored outside IDLE. Operands need to be stable only on the accepting edge.
- out_ready asserted while out_valid = 0 has no effect.
- W == DIGIT: NDIG = 1; a single RUN cycle.
- Reset asserted mid-RUN or in DONE: immediate abort, all outputs return to reset values, and the partial result is discarded.

Decomposition:
- Package addsub_seq_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - helper function computing NDIG and the counter width, clog2(NDIG) with minimum 1
- One sub-module: digit_adder, parametrised DIGIT. Combinational ripple of the existing full_adder cells.
  - Outputs: DIGIT-bit sum, carry-out, and the carry into the top bit (needed for ovf on the last digit).

Test Plan (W=16, DIGIT=4 unless noted):
- Add, basic: a=0x1234, b=0x0FFF, sub=0, cin=0 -> sum=0x2233, cout=0, ovf=0. out_valid exactly 4 cycles after accept.
- Signed overflow and wrap:
  - 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0xFFFF + 0x0000 with cin=1 -> sum=0x0000, cout=1, ovf=0.
- Subtract:
  - 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: out_valid, sum, cout and ovf stay constant; in_ready=0.
  - An in_valid pulse during this time is ignored.
  - out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-op: assert rst_n=0 after 2 RUN cycles.
  - Required: outputs zero immediately, in_ready=1 after release.
  - The next op 0x0001+0x0001 -> sum=0x0002.
- Parameter sweep: W=8/DIGIT=8 and W=12/DIGIT=1.
  - Random a, b, sub, cin (≥1000 ops each) checked against a reference model.
  - Latency must equal NDIG (1 and 12).
